// File: rtl/pulse_toggle_tx.sv
// Purpose : queue 1-cycle events and send each one as a single level change on tgl_out.
// Latency : a pulse is counted at edge N and tgl_out toggles at edge N+1 (queue empty, IDLE).
// Backpr. : one event in flight; pulses queue in a saturating counter, overflow flags drops.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   pulse_in     one event per high cycle
//   ack_tgl_in   far-side ack toggle, asynchronous, synchronised here
//   clr_ovf      clears the sticky overflow flag (a same-cycle drop wins)
//   tgl_out      toggle-encoded event line
//   busy         high while waiting for the ack of the in-flight event
//   pending      events queued and not yet sent
//   overflow     sticky: a pulse arrived while pending was saturated
//   timeout      single-cycle pulse when the ack wait reaches its limit
module pulse_toggle_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_tgl_in,
  input  logic             clr_ovf,
  output logic             tgl_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_ONE;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       pend_q, pend_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   tgl_q, tgl_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic                   timeout_q, timeout_d;

  logic ack_s;
  logic send;
  logic inc;
  logic drop;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_tgl_in};
    ack_s  = sync_q[SYNC_STAGES-1];

    send = (state_q == IDLE) && (pend_q != '0);
    // A pulse at saturation still fits when a send frees a slot in the same cycle.
    inc  = pulse_in && ((pend_q != CNT_MAX) || send);
    drop = pulse_in && !inc;

    pend_d = pend_q;
    case ({inc, send})
      2'b10:   pend_d = pend_q + CNT_ONE;
      2'b01:   pend_d = pend_q - CNT_ONE;
      default: pend_d = pend_q;
    endcase

    // A drop in the same cycle as clr_ovf keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    state_d   = state_q;
    tgl_d     = tgl_q;
    tmo_d     = tmo_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (send) begin
          tgl_d   = ~tgl_q;
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == tgl_q) begin
          state_d = IDLE;
        end else if (tmo_q != TMO_MAX) begin
          // The counter parks at its limit, so timeout fires once per handshake
          // and the event is neither resent nor abandoned.
          tmo_d = tmo_q + TMO_ONE;
          if (tmo_q == TMO_LAST) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      pend_q    <= '0;
      tmo_q     <= '0;
      tgl_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      pend_q    <= pend_d;
      tmo_q     <= tmo_d;
      tgl_q     <= tgl_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
    end
  end

  assign tgl_out  = tgl_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_pulse_toggle_tx.sv
// Purpose : random and directed stimulus for pulse_toggle_tx against an event-level model.
// Latency : model expectations are queued at each edge and checked on the next falling edge.
// Backpr. : the bench plays the far side, echoing the model's toggle after a chosen delay.
module tb_pulse_toggle_tx;

  localparam int CNT_W = 3;
  localparam int SYNC  = 2;
  localparam int TMO_W = 4;
  localparam int PMAX  = (1 << CNT_W) - 1;
  localparam int TMAX  = (1 << TMO_W) - 1;

  typedef struct packed {
    logic             tgl;
    logic             busy;
    logic [CNT_W-1:0] pend;
    logic             ovf;
    logic             tmo;
  } snap_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pulse_in = 1'b0;
  logic             ack_tgl_in = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             tgl_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             timeout;

  pulse_toggle_tx #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TMO_W      (TMO_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .ack_tgl_in(ack_tgl_in),
    .clr_ovf   (clr_ovf),
    .tgl_out   (tgl_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  snap_t exp_q[$];

  // Reference model: events waiting, one in flight, elapsed wait time.
  int m_pend   = 0;
  bit m_tgl    = 0;
  bit m_busy   = 0;
  bit m_ovf    = 0;
  bit m_tmo    = 0;
  int m_waited = 0;
  bit ack_pipe[$];

  // Far side: echoes the model's toggle ack_dly edges later unless held.
  bit tgl_hist[$];
  bit ack_r    = 0;
  bit ack_hold = 0;
  int ack_dly  = 4;

  task automatic model_step(input bit p, input bit a, input bit c, input bit r);
    bit seen;
    bit going;
    bit taken;
    bit dropped;
    if (r) begin
      m_pend = 0; m_tgl = 0; m_busy = 0; m_ovf = 0; m_tmo = 0; m_waited = 0;
      ack_pipe.delete();
      for (int i = 0; i < SYNC; i++) ack_pipe.push_back(1'b0);
      return;
    end
    seen = ack_pipe.pop_front();
    ack_pipe.push_back(a);
    going   = !m_busy && (m_pend > 0);
    taken   = p && ((m_pend < PMAX) || going);
    dropped = p && !taken;
    m_pend  = m_pend + (taken ? 1 : 0) - (going ? 1 : 0);
    if (dropped) m_ovf = 1;
    else if (c)  m_ovf = 0;
    m_tmo = 0;
    if (going) begin
      m_tgl    = !m_tgl;
      m_busy   = 1;
      m_waited = 0;
    end else if (m_busy) begin
      if (seen == m_tgl) begin
        m_busy = 0;
      end else if (m_waited < TMAX) begin
        m_waited++;
        if (m_waited == TMAX) m_tmo = 1;
      end
    end
  endtask

  task automatic cycle(input bit p, input bit c, input bit r);
    snap_t s;
    pulse_in   = p;
    clr_ovf    = c;
    rst        = r;
    ack_tgl_in = ack_r;
    @(posedge clk);
    model_step(p, ack_r, c, r);
    s.tgl  = m_tgl;
    s.busy = m_busy;
    s.pend = CNT_W'(m_pend);
    s.ovf  = m_ovf;
    s.tmo  = m_tmo;
    exp_q.push_back(s);
    if (r) begin
      tgl_hist.delete();
      ack_r = 0;
    end else begin
      tgl_hist.push_back(m_tgl);
      if (tgl_hist.size() > 32) void'(tgl_hist.pop_front());
      if (!ack_hold)
        ack_r = (tgl_hist.size() > ack_dly) ? tgl_hist[tgl_hist.size() - 1 - ack_dly] : 1'b0;
    end
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest expectation.
  initial begin
    snap_t e;
    snap_t g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{tgl_out, busy, pending, overflow, timeout};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got tgl=%b busy=%b pend=%0d ovf=%b tmo=%b, required tgl=%b busy=%b pend=%0d ovf=%b tmo=%b",
                   $time, g.tgl, g.busy, g.pend, g.ovf, g.tmo, e.tgl, e.busy, e.pend, e.ovf, e.tmo);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 300000", $time);
    $fatal(1, "watchdog");
  end

  task automatic drain(input string name, input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      cycle(0, 0, 0);
      if (pending == 0 && busy == 1'b0) done = 1;
    end
    chk(name, done, 1);
  endtask

  initial begin
    int  peak;
    int  tog;
    int  ntmo;
    int  tmo_at;
    bit  prev;
    bit  done;

    // Reset with pulse_in held high.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1);
    chk("rst_tgl", tgl_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout, 0);

    // Single event with a manually timed ack.
    ack_hold = 1;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("single_pend_after_pulse", pending, 1);
    chk("single_tgl_not_yet", tgl_out, 0);
    cycle(0, 0, 0);
    chk("single_tgl_toggled", tgl_out, 1);
    chk("single_busy", busy, 1);
    chk("single_pend_sent", pending, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    ack_r = 1;
    for (int i = 1; i <= SYNC + 1; i++) begin
      cycle(0, 0, 0);
      chk($sformatf("single_busy_after_ack_%0d", i), busy, (i < SYNC + 1) ? 1 : 0);
    end

    // Burst of five back-to-back pulses, ack loop delay 4.
    ack_hold = 0;
    ack_dly  = 4;
    peak = 0;
    tog  = 0;
    prev = tgl_out;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0);
      if (int'(pending) > peak) peak = int'(pending);
      if (tgl_out != prev) tog++;
      prev = tgl_out;
    end
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle(0, 0, 0);
      if (int'(pending) > peak) peak = int'(pending);
      if (tgl_out != prev) tog++;
      prev = tgl_out;
      if (pending == 0 && busy == 1'b0) done = 1;
    end
    chk("burst_drained", done, 1);
    chk("burst_toggles", tog, 5);
    chk("burst_peak", peak, 4);
    chk("burst_overflow", overflow, 0);

    // Saturation with the ack held off.
    ack_hold = 1;
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    chk("sat_pending", pending, PMAX);
    chk("sat_overflow", overflow, 1);
    cycle(0, 1, 0);
    chk("sat_clr_ovf", overflow, 0);
    cycle(1, 1, 0);
    chk("sat_drop_beats_clr", overflow, 1);
    chk("sat_pending_held", pending, PMAX);
    ack_hold = 0;
    drain("sat_drained", 400);
    cycle(0, 1, 0);
    chk("sat_final_clr", overflow, 0);

    // Timeout: never ack, then ack late.
    ack_hold = 1;
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    ntmo   = 0;
    tmo_at = -1;
    for (int k = 1; k <= TMAX + 10; k++) begin
      cycle(0, 0, 0);
      if (timeout) begin
        ntmo++;
        tmo_at = k;
      end
    end
    chk("tmo_count", ntmo, 1);
    chk("tmo_cycle", tmo_at, TMAX);
    chk("tmo_busy_held", busy, 1);
    ack_hold = 0;
    drain("tmo_late_ack_idle", 20);
    prev = tgl_out;
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("tmo_next_sent", tgl_out, !prev);
    drain("tmo_next_drained", 40);

    // Reset in the middle of a handshake.
    ack_hold = 1;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("midrst_pending_before", pending, 2);
    chk("midrst_busy_before", busy, 1);
    cycle(0, 0, 1);
    chk("midrst_tgl", tgl_out, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_busy", busy, 0);
    ack_hold = 0;
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("midrst_new_sent", tgl_out, 1);
    drain("midrst_drained", 40);

    // Random traffic with varying far-side delay, holds and rare resets.
    for (int n = 0; n < 3000; n++) begin
      if ((n % 64) == 0) begin
        ack_dly  = $urandom_range(6, 0);
        ack_hold = ($urandom_range(3, 0) == 0);
      end
      cycle(($urandom_range(2, 0) == 0), ($urandom_range(15, 0) == 0),
            ($urandom_range(499, 0) == 0));
    end
    ack_hold = 0;
    drain("rand_drained", 400);

    @(negedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
